// File: rtl/regfile_wb_queue.sv
// Register-file write port arbiter: ALU results take priority, long-latency results queue in a FIFO.
// Optional macro REGFILE_WB_BYPASS_EN lets an LSU result skip an empty FIFO and write straight away.
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_wb_en,
    input  logic [4:0]       alu_rd_index,
    input  logic [31:0]      alu_wb_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd_index,
    input  logic [31:0]      lsu_wb_data,
    input  logic             issue_en,
    input  logic [4:0]       issue_rd,
    output logic [31:0]      pending_mask,
    output logic             wb_en,
    output logic [4:0]       rd_index,
    output logic [31:0]      wb_data,
    output logic [PTR_W:0]   fifo_count
);
    localparam int unsigned IDX_W = 5;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned ENT_W = IDX_W + DAT_W;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pending_q, pending_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       rd_index_q, rd_index_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic             alu_sel;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             fifo_write;
    logic [ENT_W-1:0] head;

    // Ready comes only from registered occupancy, never from lsu_valid.
    assign lsu_ready = ~rst & (count_q != CNT_W'(DEPTH));

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;
        wb_en_d    = 1'b0;
        rd_index_d = rd_index_q;
        wb_data_d  = wb_data_q;
        fifo_write = 1'b0;

        alu_sel    = alu_wb_en & (alu_rd_index != 5'd0);
        fifo_empty = (count_q == CNT_W'(0));
        head       = mem_q[rd_ptr_q];
        pop        = ~alu_sel & ~fifo_empty;
`ifdef REGFILE_WB_BYPASS_EN
        bypass     = ~alu_sel & fifo_empty & lsu_valid & (lsu_rd_index != 5'd0);
`else
        bypass     = 1'b0;
`endif
        // x0 results complete the handshake but are never stored.
        push       = lsu_valid & lsu_ready & (lsu_rd_index != 5'd0) & ~bypass;

        if (alu_sel) begin
            wb_en_d    = 1'b1;
            rd_index_d = alu_rd_index;
            wb_data_d  = alu_wb_data;
        end else if (pop) begin
            wb_en_d    = 1'b1;
            rd_index_d = head[ENT_W-1:DAT_W];
            wb_data_d  = head[DAT_W-1:0];
            fifo_write = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else if (bypass) begin
            wb_en_d    = 1'b1;
            rd_index_d = lsu_rd_index;
            wb_data_d  = lsu_wb_data;
            fifo_write = 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = {lsu_rd_index, lsu_wb_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle issue to that register wins.
        if (fifo_write) begin
            pending_d[rd_index_d] = 1'b0;
        end
        if (issue_en && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            wb_en_q    <= 1'b0;
            rd_index_q <= '0;
            wb_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            wb_en_q    <= wb_en_d;
            rd_index_q <= rd_index_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pending_mask = pending_q;
    assign wb_en        = wb_en_q;
    assign rd_index     = rd_index_q;
    assign wb_data      = wb_data_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: a queue-based reference model predicts every cycle's outputs.
module tb_regfile_wb_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         alu_wb_en;
    logic [4:0]   alu_rd_index;
    logic [31:0]  alu_wb_data;
    logic         lsu_valid;
    logic         lsu_ready;
    logic [4:0]   lsu_rd_index;
    logic [31:0]  lsu_wb_data;
    logic         issue_en;
    logic [4:0]   issue_rd;
    logic [31:0]  pending_mask;
    logic         wb_en;
    logic [4:0]   rd_index;
    logic [31:0]  wb_data;
    logic [PTR_W:0] fifo_count;

    regfile_wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_en(alu_wb_en), .alu_rd_index(alu_rd_index), .alu_wb_data(alu_wb_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd_index(lsu_rd_index), .lsu_wb_data(lsu_wb_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .pending_mask(pending_mask),
        .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pm;
        int          cnt;
    } rec_t;

    ent_t        mq[$];
    rec_t        exp_q[$];
    logic [31:0] m_pm;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        rec_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("wb_en", 32'(wb_en), 32'(r.wb));
            chk("rd_index", 32'(rd_index), 32'(r.rd));
            chk("wb_data", wb_data, r.data);
            chk("pending_mask", pending_mask, r.pm);
            chk("fifo_count", 32'(fifo_count), 32'(r.cnt));
        end
    end

    task automatic idle();
        alu_wb_en = 0; alu_rd_index = 0; alu_wb_data = 0;
        lsu_valid = 0; lsu_rd_index = 0; lsu_wb_data = 0;
        issue_en = 0; issue_rd = 0;
    endtask

    // Apply current inputs for one cycle and predict the state after the next edge.
    task automatic step();
        rec_t r;
        ent_t w;
        bit   alu, byp, ready;
        #1;
        ready = (mq.size() < DEPTH);
        chk("lsu_ready", 32'(lsu_ready), 32'(!rst && ready));
        r.wb = 1'b0;
        if (rst) begin
            mq.delete();
            m_pm = 0; m_rd = 0; m_data = 0;
        end else begin
            alu = alu_wb_en && (alu_rd_index != 0);
            byp = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
            byp = (mq.size() == 0) && !alu && lsu_valid && (lsu_rd_index != 0);
`endif
            if (alu) begin
                r.wb = 1'b1; m_rd = alu_rd_index; m_data = alu_wb_data;
            end else if (mq.size() > 0) begin
                w = mq.pop_front();
                r.wb = 1'b1; m_rd = w.idx; m_data = w.data;
                m_pm[w.idx] = 1'b0;
            end else if (byp) begin
                r.wb = 1'b1; m_rd = lsu_rd_index; m_data = lsu_wb_data;
                m_pm[lsu_rd_index] = 1'b0;
            end
            if (lsu_valid && ready && (lsu_rd_index != 0) && !byp) begin
                w.idx = lsu_rd_index; w.data = lsu_wb_data;
                mq.push_back(w);
            end
            if (issue_en && issue_rd != 0) m_pm[issue_rd] = 1'b1;
            m_pm[0] = 1'b0;
        end
        r.rd = m_rd; r.data = m_data; r.pm = m_pm; r.cnt = mq.size();
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_pm = 0; m_rd = 0; m_data = 0;
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        repeat (3) step();

        // ALU write, then a dropped x0 write
        alu_wb_en = 1; alu_rd_index = 5; alu_wb_data = 32'hDEADBEEF; step();
        idle(); step();
        alu_wb_en = 1; alu_rd_index = 0; alu_wb_data = 32'h1; step();
        idle(); step();

        // Pending bit for x7 set by issue, cleared by the long-latency write
        issue_en = 1; issue_rd = 7; step();
        idle(); lsu_valid = 1; lsu_rd_index = 7; lsu_wb_data = 32'h1234; step();
        idle(); repeat (3) step();

        // ALU starves the FIFO until it fills
        for (int i = 0; i < 6; i++) begin
            alu_wb_en = 1; alu_rd_index = 1; alu_wb_data = 32'(100 + i);
            lsu_valid = 1; lsu_rd_index = 5'(10 + i); lsu_wb_data = 32'hA000 + 32'(i);
            step();
        end
        idle(); repeat (6) step();

        // Issue to x3 in the cycle its queued result is written: stays pending
        issue_en = 1; issue_rd = 3; step();
        idle(); alu_wb_en = 1; alu_rd_index = 2; alu_wb_data = 32'h22;
        lsu_valid = 1; lsu_rd_index = 3; lsu_wb_data = 32'h33; step();
        lsu_valid = 0; step();
        idle(); issue_en = 1; issue_rd = 3; step();
        idle(); repeat (2) step();

        // Reset with two entries buffered
        alu_wb_en = 1; alu_rd_index = 4; alu_wb_data = 32'h44;
        issue_en = 1; issue_rd = 8;
        lsu_valid = 1; lsu_rd_index = 8; lsu_wb_data = 32'h88; step();
        issue_en = 1; issue_rd = 9;
        lsu_rd_index = 9; lsu_wb_data = 32'h99; step();
        idle(); rst = 1; step();
        rst = 0; repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [4:0] ir;
            rst          = ($urandom_range(0, 99) == 0);
            alu_wb_en    = ($urandom_range(0, 99) < 45);
            alu_rd_index = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu_wb_data  = $urandom;
            lsu_valid    = ($urandom_range(0, 99) < 50);
            lsu_rd_index = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lsu_wb_data  = $urandom;
            ir           = 5'($urandom);
            issue_en     = ($urandom_range(0, 99) < 30) && !m_pm[ir];
            issue_rd     = ir;
            step();
        end
        rst = 0;
        idle(); repeat (8) step();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer side of the register-file write port: the single source of wb_en / rd_index / wb_data for the register file.
- Merges two result sources onto that one port:
  - the single-cycle ALU path, which has priority and is never stalled;
  - a long-latency unit (load/mul-div), buffered through a small FIFO with a valid/ready handshake.
- Keeps a pending-register scoreboard so decode can stall on registers whose long-latency results are still outstanding.

Parameters:
- DEPTH, 4: long-latency FIFO entries; power of two, minimum 2.
- PTR_W, 2: log2(DEPTH); FIFO pointer width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_wb_en  input  1  ALU result valid this cycle; always accepted.
- alu_rd_index  input  5  ALU destination register.
- alu_wb_data  input  32  ALU result.
- lsu_valid  input  1  long-latency result offered.
- lsu_ready  output  1  FIFO can accept; equals !full, and is 0 while rst=1.
- lsu_rd_index  input  5  long-latency destination register.
- lsu_wb_data  input  32  long-latency result.
- issue_en  input  1  decode issues a long-latency op this cycle.
- issue_rd  input  5  destination of the issued op.
- pending_mask  output  32  bit i = 1 while register i awaits a long-latency result; bit 0 is always 0.
- wb_en  output  1  register-file write enable (registered).
- rd_index  output  5  register-file write index (registered).
- wb_data  output  32  register-file write data (registered).
- fifo_count  output  PTR_W+1  current FIFO occupancy.

Behaviour:
- **Reset (rst=1 at a clock edge):**
  - wb_en=0, rd_index=0, wb_data=0.
  - FIFO pointers and fifo_count cleared to 0; pending_mask cleared to 0.
  - Reset mid-operation discards all buffered entries; no write issues on the cycle after reset.
- **Latency:** a source selected in cycle N appears on wb_en/rd_index/wb_data in cycle N+1. Outputs hold exactly one cycle per write. wb_en=0 when nothing is selected; rd_index and wb_data then hold their previous values.
- **Selection priority, each cycle:**
  1. If alu_wb_en=1 and alu_rd_index≠0: select the ALU. The FIFO does not pop.
  2. Else if the FIFO is non-empty: pop the head and select it.
  3. Else: nothing is selected.
- **x0 filtering:**
  - alu_wb_en with alu_rd_index=0 is dropped and does not block a FIFO pop.
  - An LSU push with lsu_rd_index=0 is accepted (the handshake completes) but not stored.
- **FIFO:**
  - Push when lsu_valid & lsu_ready.
  - Push and pop in the same cycle are allowed at any occupancy other than full. When full, lsu_ready=0, so no push occurs; a pop that cycle frees a slot for the next cycle.
  - Pointers wrap modulo DEPTH; fifo_count changes by +1, -1 or 0 per cycle.
  - lsu_ready is combinational from the registered count; it does not depend on lsu_valid.
- **Scoreboard:**
  - issue_en with issue_rd≠0 sets pending bit issue_rd.
  - A FIFO-sourced write driven onto the port clears the bit for its rd_index, in the same edge the output registers load.
  - Set and clear of the same index in the same cycle: set wins.
  - ALU writes never clear pending bits.
  - Decode must not issue a second long-latency op to a register that is already pending. Behaviour in that case is undefined: the bit clears on the first return.
- **Starvation:** continuous ALU writes starve the FIFO. This is legal; the long-latency unit sees lsu_ready=0 once the FIFO is full.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- **Defined:** if the FIFO is empty and the ALU path is not selected in that cycle, a valid LSU offer (lsu_valid=1, lsu_rd_index≠0) is routed straight to the output registers instead of being pushed. It is written in cycle N+1 with no FIFO residency, and its pending bit clears as a FIFO-sourced write. The handshake still completes with lsu_ready=1.
- **Undefined:** every LSU result is pushed first. Minimum LSU-to-write latency is 2 cycles: push in cycle N, pop in cycle N+1, write visible in cycle N+2.

Test Plan:
- Reset then idle -> wb_en=0, rd_index=0, wb_data=0, pending_mask=0, fifo_count=0, lsu_ready=1 from the first cycle after rst deasserts.
- ALU write x5=0xDEADBEEF in cycle N -> wb_en=1, rd_index=5, wb_data=0xDEADBEEF in cycle N+1 only. alu_rd_index=0 -> wb_en stays 0.
- issue_en rd=7, then LSU push x7=0x1234 with no ALU traffic -> pending_mask[7]=1 until the write cycle. Write of 0x1234 appears 2 cycles after the push (1 cycle with REGFILE_WB_BYPASS_EN), and bit 7 clears on that edge.
- ALU writes held active every cycle while the LSU offers 5 results with DEPTH=4 -> lsu_ready=0 after the 4th push and fifo_count=4. Dropping the ALU traffic drains entries in push order, one write per cycle.
- issue_en rd=3 in the same cycle that FIFO entry x3 is written -> pending_mask[3] stays 1.
- FIFO holds 2 entries, rst asserted for 1 cycle -> no writes after reset, fifo_count=0, pending_mask=0.
